// File: rtl/ffe_mac_ctrl.sv
// Sequences one FFE tap window per accepted sample: starts the external tap counter,
// steps tap_idx alongside it, frames the MAC accumulator and hands the result downstream.
//
// state | meaning
// IDLE  | waiting for an input sample, in_ready high
// START | one-cycle counter start pulse, accumulator clear
// RUN   | accumulating taps, waiting for Counter_done
// OUT   | result valid, waiting for out_ready
module ffe_mac_ctrl #(
   parameter int NUM_TAPS = 3,
   parameter int TIMEOUT  = 4,
   parameter int TAP_W    = $clog2(NUM_TAPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             Counter_enable,
   input  logic             Counter_done,
   output logic [TAP_W-1:0] tap_idx,
   output logic             acc_clear,
   output logic             acc_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_sync,
   output logic             err_timeout,
   input  logic             err_clr
);

   localparam int WD_MAX = NUM_TAPS + TIMEOUT;
   localparam int WD_W   = $clog2(WD_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [TAP_W-1:0]  tap_q, tap_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              err_sync_q, err_sync_d;
   logic              err_timeout_q, err_timeout_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tap_q         <= '0;
         wdog_q        <= '0;
         err_sync_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tap_q         <= tap_d;
         wdog_q        <= wdog_d;
         err_sync_q    <= err_sync_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tap_d         = tap_q;
      wdog_d        = wdog_q;
      // Clear first so a same-cycle error event below overrides it.
      err_sync_d    = err_clr ? 1'b0 : err_sync_q;
      err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) state_d = S_START;
         end
         S_START: begin
            tap_d   = TAP_W'(1);
            wdog_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (Counter_done) begin
               if (tap_q == TAP_W'(NUM_TAPS)) begin
                  state_d = S_OUT;
               end else begin
                  err_sync_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end else if (wdog_q == WD_W'(WD_MAX - 1)) begin
               // This cycle's increment would reach the limit: done is lost.
               err_timeout_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               if (tap_q != TAP_W'(NUM_TAPS)) tap_d = tap_q + TAP_W'(1);
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready       = (state_q == S_IDLE);
   assign Counter_enable = (state_q == S_START);
   assign acc_clear      = (state_q == S_START);
   assign acc_en         = (state_q == S_RUN);
   assign out_valid      = (state_q == S_OUT);
   assign tap_idx        = (state_q == S_RUN) ? tap_q : '0;
   assign err_sync       = err_sync_q;
   assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_ffe_mac_ctrl.sv
// Directed bench for ffe_mac_ctrl with a behavioural tap-counter model whose done
// flag can be run normally, stuck low, or forced early.
module tb_ffe_mac_ctrl;

   localparam int NUM_TAPS = 3;
   localparam int TAP_W    = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             Counter_enable;
   logic             Counter_done;
   logic [TAP_W-1:0] tap_idx;
   logic             acc_clear;
   logic             acc_en;
   logic             out_valid;
   logic             out_ready;
   logic             err_sync;
   logic             err_timeout;
   logic             err_clr;

   int checks   = 0;
   int failures = 0;

   // 0: normal counter, 1: done stuck low, 2: done forced at count 2
   int       done_mode = 0;
   logic [1:0] cnt;

   always #5 clk = ~clk;

   ffe_mac_ctrl #(.NUM_TAPS(NUM_TAPS), .TIMEOUT(4), .TAP_W(TAP_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .Counter_enable (Counter_enable),
      .Counter_done   (Counter_done),
      .tap_idx        (tap_idx),
      .acc_clear      (acc_clear),
      .acc_en         (acc_en),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .err_sync       (err_sync),
      .err_timeout    (err_timeout),
      .err_clr        (err_clr)
   );

   // Tap counter: starts at 1 after the enable pulse, wraps to 0 after max.
   always @(posedge clk) begin
      if (rst)                 cnt <= 2'd0;
      else if (Counter_enable) cnt <= 2'd1;
      else if (cnt == 2'd3)    cnt <= 2'd0;
      else if (cnt != 2'd0)    cnt <= cnt + 2'd1;
   end

   assign Counter_done = (done_mode == 1) ? 1'b0 :
                         (done_mode == 2) ? (cnt == 2'd2) : (cnt == 2'd3);

   // {in_ready, Counter_enable, acc_clear, acc_en, out_valid, tap_idx[1:0], err_sync, err_timeout}
   function automatic logic [8:0] obs();
      return {in_ready, Counter_enable, acc_clear, acc_en, out_valid, tap_idx, err_sync, err_timeout};
   endfunction

   localparam logic [8:0] O_IDLE  = 9'h100;
   localparam logic [8:0] O_START = 9'h0C0;
   localparam logic [8:0] O_RUN1  = 9'h024;
   localparam logic [8:0] O_RUN2  = 9'h028;
   localparam logic [8:0] O_RUN3  = 9'h02C;
   localparam logic [8:0] O_OUT   = 9'h010;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; done_mode = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs() !== O_IDLE) begin
         failures++;
         $display("FAIL reset_state got=%h expected=%h", obs(), O_IDLE);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [8:0] exp_tbl [1:6];
      exp_tbl[1] = O_START; exp_tbl[2] = O_RUN1; exp_tbl[3] = O_RUN2;
      exp_tbl[4] = O_RUN3;  exp_tbl[5] = O_OUT;  exp_tbl[6] = O_IDLE;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (obs() !== exp_tbl[c]) begin
            failures++;
            $display("FAIL single_cycle%0d got=%h expected=%h", c, obs(), exp_tbl[c]);
         end
      end
      checks++;
      if (Counter_done !== 1'b0) begin
         failures++;
         $display("FAIL single_counter_idle got=%b expected=0", Counter_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_v;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i > 0) @(negedge clk);
         exp_v = {(i % 6) == 0, (i % 6) == 5};
         checks++;
         if ({in_ready, out_valid} !== exp_v) begin
            failures++;
            $display("FAIL b2b_cycle%0d ready_valid got=%b expected=%b", i, {in_ready, out_valid}, exp_v);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stall();
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (obs() !== O_OUT) begin
            failures++;
            $display("FAIL stall_cycle%0d got=%h expected=%h", i, obs(), O_OUT);
         end
         if (i < 9) @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== O_IDLE) begin
            failures++;
            $display("FAIL stall_release%0d got=%h expected=%h", i, obs(), O_IDLE);
         end
      end
   endtask

   task automatic test_sync_err();
      logic [8:0] exp_tbl [1:3];
      exp_tbl[1] = O_START; exp_tbl[2] = O_RUN1; exp_tbl[3] = O_RUN2;
      done_mode = 2; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (obs() !== exp_tbl[c]) begin
            failures++;
            $display("FAIL sync_cycle%0d got=%h expected=%h", c, obs(), exp_tbl[c]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== (O_IDLE | 9'h002)) begin
            failures++;
            $display("FAIL sync_err_idle%0d got=%h expected=%h", i, obs(), O_IDLE | 9'h002);
         end
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (obs() !== O_IDLE) begin
         failures++;
         $display("FAIL sync_err_clr got=%h expected=%h", obs(), O_IDLE);
      end
      done_mode = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [8:0] exp_tbl [1:9];
      exp_tbl[1] = O_START; exp_tbl[2] = O_RUN1; exp_tbl[3] = O_RUN2;
      for (int c = 4; c <= 8; c++) exp_tbl[c] = O_RUN3;
      exp_tbl[9] = O_IDLE | 9'h001;
      done_mode = 1; out_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         in_valid = 1'b1;
         for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            err_clr  = 1'b0;
            checks++;
            if (obs() !== exp_tbl[c]) begin
               failures++;
               $display("FAIL timeout_p%0d_cycle%0d got=%h expected=%h", pass, c, obs(), exp_tbl[c]);
            end
            // Second pass: clear coincides with the timeout event.
            if (pass == 1 && c == 8) err_clr = 1'b1;
         end
         if (pass == 0) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            checks++;
            if (obs() !== O_IDLE) begin
               failures++;
               $display("FAIL timeout_clr got=%h expected=%h", obs(), O_IDLE);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (obs() !== (O_IDLE | 9'h001)) begin
         failures++;
         $display("FAIL timeout_set_wins got=%h expected=%h", obs(), O_IDLE | 9'h001);
      end
      done_mode = 0;
   endtask

   task automatic test_rst_run();
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      checks++;
      if (obs() !== (O_RUN2 | 9'h001)) begin
         failures++;
         $display("FAIL rst_pre got=%h expected=%h", obs(), O_RUN2 | 9'h001);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (obs() !== O_IDLE) begin
            failures++;
            $display("FAIL rst_run_idle%0d got=%h expected=%h", i, obs(), O_IDLE);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_sync_err();
      test_timeout();
      test_rst_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
